// File: rtl/ex_muldiv_unit_if.sv
// EX-stage request/result bundle for the iterative multiply/divide unit.
// The EX stage drives the master side; the unit is the slave.
interface ex_muldiv_unit_if #(
    parameter int DATA_SIZE = 32,
    parameter int OP_SIZE   = 3
);
    logic                 i_valid;
    logic [OP_SIZE-1:0]   i_op;
    logic [DATA_SIZE-1:0] i_data_a;
    logic [DATA_SIZE-1:0] i_data_b;
    logic                 i_flush;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_div_zero;
    logic [DATA_SIZE-1:0] o_hi;
    logic [DATA_SIZE-1:0] o_lo;

    modport master (
        output i_valid, i_op, i_data_a, i_data_b, i_flush,
        input  o_busy, o_done, o_div_zero, o_hi, o_lo
    );
    modport slave (
        input  i_valid, i_op, i_data_a, i_data_b, i_flush,
        output o_busy, o_done, o_div_zero, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Works on magnitudes and
// retires STEP_BITS bits per RUN cycle; the sign is fixed up in FINISH.
module ex_muldiv_unit #(
    parameter int DATA_SIZE = 32,
    parameter int STEP_BITS = 1,
    parameter int OP_SIZE   = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    ex_muldiv_unit_if.slave bus
);
    localparam int N     = DATA_SIZE;
    localparam int STEPS = DATA_SIZE / STEP_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [OP_SIZE-1:0] OP_MULT  = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_MULTU = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_DIV   = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_DIVU  = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] OP_MTHI  = OP_SIZE'(5);
    localparam logic [OP_SIZE-1:0] OP_MTLO  = OP_SIZE'(6);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  acc;
    logic [N-1:0]    opnd;
    logic            is_div, neg_q, neg_r, dz;
    logic            busy, done, div_zero;
    logic [N-1:0]    hi, lo;

    // request decode: magnitudes of the operands for signed ops
    logic            req_div, req_signed, a_neg, b_neg, req_muldiv;
    logic [N-1:0]    a_abs, b_abs;

    always_comb begin
        req_div    = (bus.i_op == OP_DIV) || (bus.i_op == OP_DIVU);
        req_signed = (bus.i_op == OP_DIV) || (bus.i_op == OP_MULT);
        req_muldiv = req_div || (bus.i_op == OP_MULT) || (bus.i_op == OP_MULTU);
        a_neg      = req_signed & bus.i_data_a[N-1];
        b_neg      = req_signed & bus.i_data_b[N-1];
        a_abs      = a_neg ? -bus.i_data_a : bus.i_data_a;
        b_abs      = b_neg ? -bus.i_data_b : bus.i_data_b;
    end

    // One RUN cycle: STEP_BITS iterations of shift-add (mul) or restoring
    // divide. For divide acc holds {remainder, dividend/quotient}.
    logic [2*N-1:0]  acc_step;
    logic [N:0]      part, diff, sum;

    always_comb begin
        acc_step = acc;
        part     = '0;
        diff     = '0;
        sum      = '0;
        for (int j = 0; j < STEP_BITS; j++) begin
            if (is_div) begin
                part = acc_step[2*N-1:N-1];
                diff = part - {1'b0, opnd};
                if (!diff[N]) acc_step = {diff[N-1:0], acc_step[N-2:0], 1'b1};
                else          acc_step = {part[N-1:0], acc_step[N-2:0], 1'b0};
            end else begin
                sum      = {1'b0, acc_step[2*N-1:N]} + (acc_step[0] ? {1'b0, opnd} : '0);
                acc_step = {sum, acc_step[N-1:1]};
            end
        end
    end

    logic [2*N-1:0]  prod_fix;
    logic [N-1:0]    quo_fix, rem_fix;

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[N-1:0] : acc[N-1:0];
        rem_fix  = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_valid && !bus.i_flush) begin
                        if (req_muldiv) begin
                            opnd   <= req_div ? b_abs : a_abs;
                            acc    <= {{N{1'b0}}, (req_div ? a_abs : b_abs)};
                            is_div <= req_div;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            dz     <= req_div && (bus.i_data_b == '0);
                            cnt    <= CW'(STEPS);
                            busy   <= 1'b1;
                            state  <= RUN;
                        end else if (bus.i_op == OP_MTHI) begin
                            hi <= bus.i_data_a;
                        end else if (bus.i_op == OP_MTLO) begin
                            lo <= bus.i_data_a;
                        end
                    end
                end
                RUN: begin
                    if (bus.i_flush) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= FINISH;
                    end
                end
                FINISH: begin
                    if (!bus.i_flush) begin
                        if (is_div) begin
                            // divide by zero: all-ones quotient, remainder is the dividend
                            lo       <= dz ? '1 : quo_fix;
                            hi       <= rem_fix;
                            div_zero <= dz;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        done <= 1'b1;
                    end
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy     = busy;
    assign bus.o_done     = done;
    assign bus.o_div_zero = div_zero;
    assign bus.o_hi       = hi;
    assign bus.o_lo       = lo;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: random ops against an arithmetic reference model,
// plus literal cases for known products/quotients, flush, reset and STEP_BITS=4.
module tb_ex_muldiv_unit;
    localparam int N = 32;
    localparam int LAT1 = N / 1 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.DATA_SIZE(N), .OP_SIZE(3)) bus  ();
    ex_muldiv_unit_if #(.DATA_SIZE(N), .OP_SIZE(3)) bus4 ();

    ex_muldiv_unit #(.DATA_SIZE(N), .STEP_BITS(1), .OP_SIZE(3)) dut  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    ex_muldiv_unit #(.DATA_SIZE(N), .STEP_BITS(4), .OP_SIZE(3)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // {HI,LO} an instruction must leave behind, from plain arithmetic
    function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: r = 64'(sa * sb);
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: if (b == 0) r = {a, 32'hFFFF_FFFF};
                  else        r = {32'(sa % sb), 32'(sa / sb)};
            3'd4: if (b == 0) r = {a, 32'hFFFF_FFFF};
                  else        r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // cycle-level expectation: an op is in flight for LAT1 edges then retires
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] p_res = '0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_busy) begin
                if (bus.i_flush) m_busy <= 1'b0;
                else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                        m_dz   <= p_dz;
                        {m_hi, m_lo} <= p_res;
                    end
                end
            end else if (bus.i_valid && !bus.i_flush) begin
                if (bus.i_op >= 3'd1 && bus.i_op <= 3'd4) begin
                    p_res  <= ref_calc(bus.i_op, bus.i_data_a, bus.i_data_b);
                    p_dz   <= (bus.i_op >= 3'd3) && (bus.i_data_b == 0);
                    m_left <= LAT1;
                    m_busy <= 1'b1;
                end else if (bus.i_op == 3'd5) m_hi <= bus.i_data_a;
                else if (bus.i_op == 3'd6)     m_lo <= bus.i_data_a;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", bus.o_busy, m_busy);
        chk("done", bus.o_done, m_done);
        chk("div_zero", bus.o_div_zero, m_dz);
        chk("hi", bus.o_hi, m_hi);
        chk("lo", bus.o_lo, m_lo);
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); #1;
        bus.i_valid = 1'b1; bus.i_op = op; bus.i_data_a = a; bus.i_data_b = b;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_op = 3'd0;
    endtask

    task automatic wait_done(output int busy_cnt);
        logic ok;
        busy_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_done) begin ok = 1'b1; break; end
            if (bus.o_busy) busy_cnt++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no o_done, expected one within 100 cycles");
        end
    endtask

    task automatic issue4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); #1;
        bus4.i_valid = 1'b1; bus4.i_op = op; bus4.i_data_a = a; bus4.i_data_b = b;
        @(posedge clk); #1;
        bus4.i_valid = 1'b0; bus4.i_op = 3'd0;
    endtask

    task automatic wait_done4(output int busy_cnt);
        logic ok;
        busy_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus4.o_done) begin ok = 1'b1; break; end
            if (bus4.o_busy) busy_cnt++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL done4_timeout: got no o_done, expected one within 40 cycles");
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom());
        endcase
    endfunction

    function automatic logic [2:0] rnd_op();
        int r;
        r = int'($urandom_range(0, 11));
        if (r < 8)       return 3'(1 + r % 4);
        else if (r < 10) return 3'(5 + r % 2);
        else if (r == 10) return 3'd0;
        else              return 3'd7;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [31:0] lo_before, a, b;
        logic [2:0] op;
        logic seen;

        bus.i_valid = 0; bus.i_op = 0; bus.i_data_a = 0; bus.i_data_b = 0; bus.i_flush = 0;
        bus4.i_valid = 0; bus4.i_op = 0; bus4.i_data_a = 0; bus4.i_data_b = 0; bus4.i_flush = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.o_busy, 1'b0);
        chk("reset_hi", bus.o_hi, 32'h0);
        chk("reset_lo", bus.o_lo, 32'h0);
        #1 rst_n = 1'b1;

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cnt);
        chk("multu_hi", bus.o_hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.o_lo, 32'h0000_0001);
        chk("multu_latency", cnt, 33);

        issue(3'd1, -32'sd3, 32'd7);
        wait_done(cnt);
        chk("mult_hi", bus.o_hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.o_lo, 32'hFFFF_FFEB);
        chk("mult_busy_cycles", cnt, 33);

        issue(3'd3, -32'sd7, 32'd2);
        wait_done(cnt);
        chk("div_lo", bus.o_lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.o_hi, 32'hFFFF_FFFF);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cnt);
        chk("div_ovf_lo", bus.o_lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.o_hi, 32'h0);

        issue(3'd4, 32'd10, 32'd0);
        wait_done(cnt);
        chk("divz_lo", bus.o_lo, 32'hFFFF_FFFF);
        chk("divz_hi", bus.o_hi, 32'h0000_000A);
        chk("divz_flag", bus.o_div_zero, 1'b1);

        // MTHI, then a MULT that is squashed; a request during RUN is dropped
        issue(3'd5, 32'h1234, 32'd0);
        @(negedge clk);
        chk("mthi", bus.o_hi, 32'h1234);
        lo_before = bus.o_lo;
        issue(3'd1, 32'd5, 32'd6);
        repeat (3) @(negedge clk);
        #1 bus.i_valid = 1'b1; bus.i_op = 3'd6; bus.i_data_a = 32'hDEAD;
        @(posedge clk); #1 bus.i_valid = 1'b0; bus.i_op = 3'd0;
        repeat (5) @(negedge clk);
        #1 bus.i_flush = 1'b1;
        @(posedge clk); #1 bus.i_flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", bus.o_busy, 1'b0);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.o_done) seen = 1'b1; end
        chk("flush_no_done", seen, 1'b0);
        chk("flush_hi_kept", bus.o_hi, 32'h1234);
        chk("flush_lo_kept", bus.o_lo, lo_before);

        // flush in IDLE wins over a request
        @(negedge clk); #1;
        bus.i_valid = 1'b1; bus.i_op = 3'd1; bus.i_data_a = 32'd3; bus.i_data_b = 32'd3; bus.i_flush = 1'b1;
        @(posedge clk); #1 bus.i_valid = 1'b0; bus.i_op = 3'd0; bus.i_flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_blocks", bus.o_busy, 1'b0);

        // reset in the middle of a DIVU
        issue(3'd4, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", bus.o_busy, 1'b0);
        chk("rst_mid_hi", bus.o_hi, 32'h0);
        chk("rst_mid_lo", bus.o_lo, 32'h0);
        @(negedge clk); #1 rst_n = 1'b1;

        for (int it = 0; it < 60; it++) begin
            op = rnd_op(); a = rnd_val(); b = rnd_val();
            issue(op, a, b);
            if (op >= 3'd1 && op <= 3'd4) begin
                if ($urandom_range(0, 9) == 0) begin
                    repeat ($urandom_range(1, 30)) @(negedge clk);
                    #1 bus.i_flush = 1'b1;
                    @(posedge clk); #1 bus.i_flush = 1'b0;
                    repeat (2) @(negedge clk);
                end else begin
                    wait_done(cnt);
                    chk("rand_result", {bus.o_hi, bus.o_lo}, ref_calc(op, a, b));
                end
            end else begin
                @(negedge clk);
            end
        end

        issue4(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done4(cnt);
        chk("s4_multu_hi", bus4.o_hi, 32'hFFFF_FFFE);
        chk("s4_multu_lo", bus4.o_lo, 32'h0000_0001);
        chk("s4_latency", cnt, 9);
        for (int it = 0; it < 20; it++) begin
            op = 3'(1 + $urandom_range(0, 3)); a = rnd_val(); b = rnd_val();
            issue4(op, a, b);
            wait_done4(cnt);
            chk("s4_rand_result", {bus4.o_hi, bus4.o_lo}, ref_calc(op, a, b));
            chk("s4_rand_dz", bus4.o_div_zero, (op >= 3'd3) && (b == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
